// File: rtl/ifm_pingpong_buffer.sv
// Two-bank ping-pong feature-map store: producer fills one bank while the consumer drains the other.
// Latency: reads 1 cycle; start_from_previous -> start_to_next 2 edges; end_from_next -> bank_free/end_to_previous 1 edge.
// Backpressure: bank ownership handshake only (start/end pulses); optional PINGPONG_PROTOCOL_CHECK_EN adds write gating and a sticky protocol_error.
module ifm_pingpong_buffer #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 14,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ifm_enable_write,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        ifm_sel,
  input  logic                        start_from_previous,
  output logic                        end_to_previous,
  output logic [1:0]                  bank_free,
  input  logic                        ifm_enable_read_A,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A,
  input  logic                        ifm_enable_read_B,
  input  logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B,
  output logic [DATA_WIDTH-1:0]       data_out_A,
  output logic [DATA_WIDTH-1:0]       data_out_B,
  output logic                        start_to_next,
  input  logic                        end_from_next,
  output logic                        read_sel,
  output logic                        protocol_error
);

  localparam int DEPTH = IFM_SIZE*IFM_SIZE;

  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READ} bank_st_e;
  typedef enum logic {S_IDLE, S_BUSY} rd_st_e;

  // storage, not reset
  logic [DATA_WIDTH-1:0] ram [2][DEPTH];

  bank_st_e bank_st_q [2];
  bank_st_e bank_st_d [2];
  rd_st_e   state_q, state_d;
  logic     read_sel_q, read_sel_d;
  logic     fill_order_q, fill_order_d;
  logic     start_to_next_q, start_to_next_d;
  logic     end_to_previous_q, end_to_previous_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic     wr_en;
  logic     full0, full1;
  logic     grant_bank;

  assign full0 = (bank_st_q[0] == B_FULL);
  assign full1 = (bank_st_q[1] == B_FULL);

`ifdef PINGPONG_PROTOCOL_CHECK_EN
  logic perr_q, perr_d;
  // a write only lands in a bank the producer still owns
  assign wr_en = ifm_enable_write && (bank_st_q[ifm_sel] == B_EMPTY);
  assign protocol_error = perr_q;
`else
  // producer is trusted: writes always land
  assign wr_en = ifm_enable_write;
  assign protocol_error = 1'b0;
`endif

  // RAM write port; a write in the same cycle the bank is marked FULL still commits
  always_ff @(posedge clk) begin
    if (wr_en) ram[ifm_sel][ifm_address_write] <= data_in;
  end

  // read ports sample the consumer's bank; hold when not strobed
  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (ifm_enable_read_A) data_a_d = ram[read_sel_q][ifm_address_read_A];
    if (ifm_enable_read_B) data_b_d = ram[read_sel_q][ifm_address_read_B];
  end

  // bank ownership, fill ordering and reader FSM next-state
  always_comb begin
    bank_st_d         = bank_st_q;
    state_d           = state_q;
    read_sel_d        = read_sel_q;
    fill_order_d      = fill_order_q;
    start_to_next_d   = 1'b0;
    end_to_previous_d = 1'b0;
    grant_bank        = (full0 && full1) ? fill_order_q : full1;
`ifdef PINGPONG_PROTOCOL_CHECK_EN
    perr_d = perr_q;
    if (ifm_enable_write && (bank_st_q[ifm_sel] != B_EMPTY)) perr_d = 1'b1;
`endif

    // producer hands over a filled bank; remember it as oldest if the other is not waiting
    if (start_from_previous) begin
      if (bank_st_q[ifm_sel] == B_EMPTY) begin
        bank_st_d[ifm_sel] = B_FULL;
        if (bank_st_q[~ifm_sel] != B_FULL) fill_order_d = ifm_sel;
      end
`ifdef PINGPONG_PROTOCOL_CHECK_EN
      else begin
        perr_d = 1'b1;
      end
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (full0 || full1) begin
          bank_st_d[grant_bank] = B_READ;
          read_sel_d            = grant_bank;
          start_to_next_d       = 1'b1;
          state_d               = S_BUSY;
        end
`ifdef PINGPONG_PROTOCOL_CHECK_EN
        if (end_from_next) perr_d = 1'b1;
`endif
      end
      S_BUSY: begin
        if (end_from_next) begin
          bank_st_d[read_sel_q] = B_EMPTY;
          end_to_previous_d     = 1'b1;
          state_d               = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_st_q[0]      <= B_EMPTY;
      bank_st_q[1]      <= B_EMPTY;
      state_q           <= S_IDLE;
      read_sel_q        <= 1'b0;
      fill_order_q      <= 1'b0;
      start_to_next_q   <= 1'b0;
      end_to_previous_q <= 1'b0;
      data_a_q          <= '0;
      data_b_q          <= '0;
    end else begin
      bank_st_q         <= bank_st_d;
      state_q           <= state_d;
      read_sel_q        <= read_sel_d;
      fill_order_q      <= fill_order_d;
      start_to_next_q   <= start_to_next_d;
      end_to_previous_q <= end_to_previous_d;
      data_a_q          <= data_a_d;
      data_b_q          <= data_b_d;
    end
  end

`ifdef PINGPONG_PROTOCOL_CHECK_EN
  // sticky illegal-event flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
`endif

  assign bank_free       = {bank_st_q[1] == B_EMPTY, bank_st_q[0] == B_EMPTY};
  assign read_sel        = read_sel_q;
  assign start_to_next   = start_to_next_q;
  assign end_to_previous = end_to_previous_q;
  assign data_out_A      = data_a_q;
  assign data_out_B      = data_b_q;

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Bench for ifm_pingpong_buffer: directed handshake scenarios with literal checks, then random
// traffic compared every cycle against a queue-based ownership model.
module tb_ifm_pingpong_buffer;

  localparam int DW = 32;
  localparam int N  = 196;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ifm_enable_write = 1'b0;
  logic [AW-1:0] ifm_address_write = '0;
  logic [DW-1:0] data_in = '0;
  logic          ifm_sel = 1'b0;
  logic          start_from_previous = 1'b0;
  logic          end_to_previous;
  logic [1:0]    bank_free;
  logic          ifm_enable_read_A = 1'b0;
  logic [AW-1:0] ifm_address_read_A = '0;
  logic          ifm_enable_read_B = 1'b0;
  logic [AW-1:0] ifm_address_read_B = '0;
  logic [DW-1:0] data_out_A;
  logic [DW-1:0] data_out_B;
  logic          start_to_next;
  logic          end_from_next = 1'b0;
  logic          read_sel;
  logic          protocol_error;

  int tests = 0;
  int fails = 0;

  ifm_pingpong_buffer dut (
    .clk                 (clk),
    .reset               (reset),
    .ifm_enable_write    (ifm_enable_write),
    .ifm_address_write   (ifm_address_write),
    .data_in             (data_in),
    .ifm_sel             (ifm_sel),
    .start_from_previous (start_from_previous),
    .end_to_previous     (end_to_previous),
    .bank_free           (bank_free),
    .ifm_enable_read_A   (ifm_enable_read_A),
    .ifm_address_read_A  (ifm_address_read_A),
    .ifm_enable_read_B   (ifm_enable_read_B),
    .ifm_address_read_B  (ifm_address_read_B),
    .data_out_A          (data_out_A),
    .data_out_B          (data_out_B),
    .start_to_next       (start_to_next),
    .end_from_next       (end_from_next),
    .read_sel            (read_sel),
    .protocol_error      (protocol_error)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // bank state: 0 empty (producer owns), 1 full (waiting), 2 being read
  int          st [2];
  int          fullq [$];          // full banks, oldest first
  bit          busy;
  bit          rsel;
  bit          e_stn, e_etp, e_perr;
  logic [DW-1:0] e_da, e_db;
  bit          e_da_k, e_db_k;     // expected read data is defined
  logic [DW-1:0] mem [2][N];
  bit          vld [2][N];

  task automatic model_reset();
    st[0] = 0; st[1] = 0;
    fullq.delete();
    busy = 0; rsel = 0;
    e_stn = 0; e_etp = 0; e_perr = 0;
    e_da = '0; e_db = '0; e_da_k = 1; e_db_k = 1;
  endtask

  task automatic model_step();
    int  st_old [2];
    bit  wr;
    int  b;
    st_old = st;
    if (ifm_enable_read_A) begin
      e_da = mem[rsel][ifm_address_read_A]; e_da_k = vld[rsel][ifm_address_read_A];
    end
    if (ifm_enable_read_B) begin
      e_db = mem[rsel][ifm_address_read_B]; e_db_k = vld[rsel][ifm_address_read_B];
    end
    wr = ifm_enable_write;
`ifdef PINGPONG_PROTOCOL_CHECK_EN
    if (ifm_enable_write && st_old[ifm_sel] != 0) begin
      wr = 0; e_perr = 1;
    end
`endif
    if (wr) begin
      mem[ifm_sel][ifm_address_write] = data_in;
      vld[ifm_sel][ifm_address_write] = 1;
    end
    e_stn = 0; e_etp = 0;
    if (!busy) begin
      if (fullq.size() > 0) begin
        b = fullq.pop_front();
        st[b] = 2; rsel = b[0]; busy = 1; e_stn = 1;
      end
`ifdef PINGPONG_PROTOCOL_CHECK_EN
      if (end_from_next) e_perr = 1;
`endif
    end else if (end_from_next) begin
      st[rsel] = 0; busy = 0; e_etp = 1;
    end
    if (start_from_previous) begin
      if (st_old[ifm_sel] == 0) begin
        st[ifm_sel] = 1; fullq.push_back(int'(ifm_sel));
      end
`ifdef PINGPONG_PROTOCOL_CHECK_EN
      else e_perr = 1;
`endif
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: model follows the edge, then single-cycle strobes drop
  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    ifm_enable_write = 0; start_from_previous = 0; end_from_next = 0;
    ifm_enable_read_A = 0; ifm_enable_read_B = 0;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("start_to_next", {31'b0, start_to_next}, {31'b0, e_stn});
    chk("end_to_previous", {31'b0, end_to_previous}, {31'b0, e_etp});
    chk("bank_free", {30'b0, bank_free}, {30'b0, st[1] == 0, st[0] == 0});
    chk("read_sel", {31'b0, read_sel}, {31'b0, rsel});
    chk("protocol_error", {31'b0, protocol_error}, {31'b0, e_perr});
    if (e_da_k) chk("data_out_A", data_out_A, e_da);
    if (e_db_k) chk("data_out_B", data_out_B, e_db);
  end

  task automatic fill(input bit bank, input int base);
    for (int a = 0; a < N; a++) begin
      ifm_enable_write = 1; ifm_sel = bank; ifm_address_write = AW'(a); data_in = DW'(a + base);
      tick();
    end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) for (int a = 0; a < N; a++) begin mem[b][a] = 'x; vld[b][a] = 0; end
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    chk("reset bank_free", {30'b0, bank_free}, 32'd3);
    chk("reset start_to_next", {31'b0, start_to_next}, 32'd0);
    chk("reset data_out_A", data_out_A, 32'd0);
    reset = 1;

    // bank 0 fill and hand-over
    fill(0, 100);
    start_from_previous = 1; ifm_sel = 0;
    tick();
    @(negedge clk);
    chk("t0 bank_free full", {30'b0, bank_free}, 32'd2);
    chk("t0 no start yet", {31'b0, start_to_next}, 32'd0);
    tick();
    @(negedge clk);
    chk("grant0 start_to_next", {31'b0, start_to_next}, 32'd1);
    chk("grant0 read_sel", {31'b0, read_sel}, 32'd0);
    chk("grant0 bank_free", {30'b0, bank_free}, 32'd2);

    // dual read
    ifm_enable_read_A = 1; ifm_address_read_A = 8'd5;
    ifm_enable_read_B = 1; ifm_address_read_B = 8'd195;
    tick();
    @(negedge clk);
    chk("read A addr5", data_out_A, 32'd105);
    chk("read B addr195", data_out_B, 32'd295);

    // bank 1 filled while 0 is read, then release 0
    fill(1, 1000);
    start_from_previous = 1; ifm_sel = 1;
    tick();
    end_from_next = 1;
    tick();
    @(negedge clk);
    chk("release0 end_to_previous", {31'b0, end_to_previous}, 32'd1);
    chk("release0 bank_free0", {31'b0, bank_free[0]}, 32'd1);
    tick();
    @(negedge clk);
    chk("grant1 start_to_next", {31'b0, start_to_next}, 32'd1);
    chk("grant1 read_sel", {31'b0, read_sel}, 32'd1);

    // simultaneous start(bank0)+end(bank1), with a same-cycle write to bank 0
    fill(0, 2000);
    start_from_previous = 1; ifm_sel = 0; end_from_next = 1;
    ifm_enable_write = 1; ifm_address_write = 8'd7; data_in = 32'h777;
    tick();
    @(negedge clk);
    chk("simul end_to_previous", {31'b0, end_to_previous}, 32'd1);
    chk("simul bank_free", {30'b0, bank_free}, 32'd2);
    tick();
    @(negedge clk);
    chk("simul grant0", {31'b0, start_to_next}, 32'd1);
    chk("simul read_sel", {31'b0, read_sel}, 32'd0);
    ifm_enable_read_A = 1; ifm_address_read_A = 8'd7;
    tick();
    @(negedge clk);
    chk("same-cycle write", data_out_A, 32'h777);

    // write into the bank being read
    ifm_enable_write = 1; ifm_sel = 0; ifm_address_write = 8'd3; data_in = 32'hDEAD;
    tick();
    ifm_enable_read_B = 1; ifm_address_read_B = 8'd3;
    tick();
    repeat (3) tick();
    @(negedge clk);
`ifdef PINGPONG_PROTOCOL_CHECK_EN
    chk("illegal write dropped", data_out_B, 32'd2003);
    chk("protocol_error sticky", {31'b0, protocol_error}, 32'd1);
`else
    chk("trusted write lands", data_out_B, 32'hDEAD);
    chk("protocol_error tied", {31'b0, protocol_error}, 32'd0);
`endif

    // asynchronous reset while busy
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("arst start_to_next", {31'b0, start_to_next}, 32'd0);
    chk("arst end_to_previous", {31'b0, end_to_previous}, 32'd0);
    chk("arst bank_free", {30'b0, bank_free}, 32'd3);
    chk("arst read_sel", {31'b0, read_sel}, 32'd0);
    chk("arst protocol_error", {31'b0, protocol_error}, 32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1;
    repeat (3) tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      ifm_enable_write = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)      ifm_sel = 1'($urandom_range(0, 1));
      else if (st[0] == 0)               ifm_sel = 0;
      else if (st[1] == 0)               ifm_sel = 1;
      else                               ifm_sel = 1'($urandom_range(0, 1));
      ifm_address_write   = AW'($urandom_range(0, N-1));
      data_in             = $urandom;
      start_from_previous = ($urandom_range(0, 11) == 0);
      end_from_next       = busy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
      ifm_enable_read_A   = 1'($urandom_range(0, 1));
      ifm_address_read_A  = AW'($urandom_range(0, N-1));
      ifm_enable_read_B   = 1'($urandom_range(0, 1));
      ifm_address_read_B  = ($urandom_range(0, 7) == 0) ? ifm_address_read_A : AW'($urandom_range(0, N-1));
      tick();
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
